// File: rtl/cpu_controller_pkg.sv
// Shared types and constants for the instruction-sequencing controller:
// FSM state encoding, ISA opcode/op fields, ALU operation codes and the
// imm8 sign-extension helper.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    WRITE_IMM = 3'd2,
    GET_A     = 3'd3,
    GET_B     = 3'd4,
    ALU       = 3'd5,
    WRITE_REG = 3'd6
  } state_t;

  // Major opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Minor op field IR[12:11] under OPC_ALU
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // Minor op field IR[12:11] under OPC_MOV
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  // ALUop encodings seen by the datapath
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Sign-extend an 8-bit immediate to the 16-bit datapath width
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Bundle of instruction input, handshake and datapath control strobes
// between the controller (slave) and whoever drives instructions and
// observes the strobes (master).
interface cpu_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [15:0] datapath_in;
  logic        vsel;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;

  modport master (
    output in, load, s,
    input  w, datapath_in, vsel, writenum, write, readnum, loada, loadb,
           shift, asel, bsel, ALUop, loadc, loads
  );

  modport slave (
    input  in, load, s,
    output w, datapath_in, vsel, writenum, write, readnum, loada, loadb,
           shift, asel, bsel, ALUop, loadc, loads
  );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Pure combinational slicing of the instruction register into its fields,
// plus the sign-extended imm8 that feeds datapath_in.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] imm_sext
);

  assign opcode   = ir[15:13];
  assign op       = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign sh       = ir[4:3];
  assign rm       = ir[2:0];
  assign imm_sext = sext8(ir[7:0]);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM that sequences the datapath strobes
// for MOV imm, MOV reg, ADD, CMP, AND and MVN. All strobes depend only on
// the current state and IR, so they are stable for the whole cycle.
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.slave  bus
);

  logic [15:0] ir;
  state_t      state;
  state_t      state_next;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  sh;
  logic [2:0]  rm;
  logic [15:0] imm_sext;

  logic        w;
  logic        vsel;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic [1:0]  alu_op;
  logic        loadc;
  logic        loads;

  instr_decoder u_decoder (
    .ir       (ir),
    .opcode   (opcode),
    .op       (op),
    .rn       (rn),
    .rd       (rd),
    .sh       (sh),
    .rm       (rm),
    .imm_sext (imm_sext)
  );

  // Instruction register: only accepts a new word while idle in WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= 16'h0000;
    end else if (state == WAIT && bus.load) begin
      ir <= bus.in;
    end else begin
      ir <= ir;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; unsupported encodings fall straight back to WAIT
  always_comb begin
    state_next = state;
    case (state)
      WAIT: begin
        if (bus.s) state_next = DECODE;
        else       state_next = WAIT;
      end
      DECODE: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
          state_next = WRITE_IMM;
        end else if ((opcode == OPC_MOV && op == OP_MOV_REG) ||
                     (opcode == OPC_ALU && op == OP_MVN)) begin
          state_next = GET_B;
        end else if (opcode == OPC_ALU) begin
          state_next = GET_A;
        end else begin
          state_next = WAIT;
        end
      end
      GET_A:     state_next = GET_B;
      GET_B:     state_next = ALU;
      ALU: begin
        if (opcode == OPC_ALU && op == OP_CMP) state_next = WAIT;
        else                                   state_next = WRITE_REG;
      end
      WRITE_IMM: state_next = WAIT;
      WRITE_REG: state_next = WAIT;
      default:   state_next = WAIT;
    endcase
  end

  // Moore output decode: everything defaults to 0, each state raises its own strobes
  always_comb begin
    w        = 1'b0;
    vsel     = 1'b0;
    writenum = 3'd0;
    write    = 1'b0;
    readnum  = 3'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    shift    = 2'b00;
    asel     = 1'b0;
    alu_op   = ALU_ADD;
    loadc    = 1'b0;
    loads    = 1'b0;
    case (state)
      WAIT: begin
        w = 1'b1;
      end
      DECODE: begin
        w = 1'b0;
      end
      WRITE_IMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = rn;
      end
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      ALU: begin
        shift = sh;
        if (opcode == OPC_ALU) begin
          // CMP only updates the status flag, C is left untouched
          asel   = 1'b0;
          alu_op = op;
          loads  = 1'b1;
          loadc  = (op != OP_CMP);
        end else begin
          // MOV reg: 0 + shifted B passes Rm through the ALU
          asel   = 1'b1;
          alu_op = ALU_ADD;
          loads  = 1'b0;
          loadc  = 1'b1;
        end
      end
      WRITE_REG: begin
        vsel     = 1'b0;
        write    = 1'b1;
        writenum = rd;
      end
      default: begin
        w = 1'b0;
      end
    endcase
  end

  assign bus.w           = w;
  assign bus.datapath_in = imm_sext;
  assign bus.vsel        = vsel;
  assign bus.writenum    = writenum;
  assign bus.write       = write;
  assign bus.readnum     = readnum;
  assign bus.loada       = loada;
  assign bus.loadb       = loadb;
  assign bus.shift       = shift;
  assign bus.asel        = asel;
  assign bus.bsel        = 1'b0;
  assign bus.ALUop       = alu_op;
  assign bus.loadc       = loadc;
  assign bus.loads       = loads;

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Upstream control stage for the 16-bit datapath: holds the instruction register, decodes fields, and sequences the datapath control strobes with a Moore FSM.
- Supported instructions: MOV Rn,#imm8; MOV Rd,Rm{,sh}; ADD, CMP, AND, MVN.
- Drives every datapath control input plus datapath_in, and reports completion through w.

Parameters:
- none (widths fixed by ISA: 16-bit instruction, 3-bit register index)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in  in  16  instruction word
- load  in  1  capture in into IR (honoured only in WAIT)
- s  in  1  start execution (sampled only in WAIT)
- w  out  1  1 = idle in WAIT, ready for load/s
- datapath_in  out  16  sign-extended imm8 (IR[7:0] -> 16 bits), combinational from IR
- vsel  out  1  1 = write datapath_in, 0 = write C
- writenum  out  3  register file write index
- write  out  1  register file write enable
- readnum  out  3  register file read index
- loada  out  1  load A
- loadb  out  1  load B
- shift  out  2  shifter op
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  1 = B operand from datapath_in[4:0]; this block always drives 0
- ALUop  out  2  00 ADD, 01 SUB/CMP, 10 AND, 11 NOT B
- loadc  out  1  load C
- loads  out  1  load status (Z)

Behaviour:
- IR fields:
  - opcode = IR[15:13]
  - op = IR[12:11]
  - Rn = IR[10:8]
  - Rd = IR[7:5]
  - sh = IR[4:3]
  - Rm = IR[2:0]
  - imm8 = IR[7:0]
- Reset (async, immediate): state = WAIT, IR = 0, w = 1, all other outputs 0 (datapath_in = 0).
- IR update: IR <= in on a clk edge with load=1 and state = WAIT; load is ignored in all other states.
- Outputs are a pure function of state and IR (Moore). Every output not listed for a state is 0.
- States and outputs:
  - WAIT: w=1.
  - DECODE: all strobes 0.
  - WRITE_IMM: vsel=1, write=1, writenum=Rn.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU: shift=sh, bsel=0, loadc=1 (except CMP). For MOV reg: asel=1, ALUop=00, loads=0. For opcode 101: asel=0, ALUop=op, loads=1.
  - WRITE_REG: vsel=0, write=1, writenum=Rd.
- Transitions:
  - WAIT -> DECODE when s=1, otherwise stay.
  - DECODE -> WRITE_IMM for opcode 110, op 10.
  - DECODE -> GET_B for opcode 110, op 00 and for opcode 101, op 11.
  - DECODE -> GET_A for opcode 101, op 00/01/10.
  - DECODE -> WAIT for any other encoding (no-op, no strobes).
  - GET_A -> GET_B; GET_B -> ALU.
  - ALU -> WAIT for CMP; ALU -> WRITE_REG otherwise.
  - WRITE_IMM and WRITE_REG -> WAIT.
- Latency (clk edges from the s-sampling edge until w=1): MOV imm 3; MOV reg, MVN and CMP 5; ADD and AND 6.
- load and s both high in WAIT on the same edge: IR captures the new word and DECODE executes the new word.
- s held high continuously: the next instruction starts on the first edge after WAIT is re-entered, giving back-to-back execution with one WAIT cycle.
- Reset asserted mid-instruction: immediate return to WAIT with all strobes 0. A partially executed instruction writes nothing further.

Decomposition:
- Package cpu_ctrl_pkg:
  - state encoding enum: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG
  - opcode constants OPC_MOV=110, OPC_ALU=101
  - op constants ADD/CMP/AND/MVN, MOV_IMM/MOV_REG
  - ALUop constants
- Sub-module instr_decoder: combinational field extraction and sign extension of imm8. FSM and IR stay in cpu_controller.

Test Plan:
- Reset mid-ADD (assert reset in GET_B) -> all outputs 0 and w=1 immediately. Then load 0xD007 and pulse s -> DECODE, then WRITE_IMM with writenum=0, vsel=1, write=1, datapath_in=0x0007; w=1 three edges after s.
- Load 0xD3FF (MOV R3,#-1) -> datapath_in=0xFFFF, writenum=3 in WRITE_IMM.
- Load 0xA148 (ADD R2,R1,R0,LSL#1) -> three strobe cycles:
  - GET_A: readnum=1, loada=1
  - GET_B: readnum=0, loadb=1
  - ALU: shift=01, ALUop=00, asel=0, loadc=1, loads=1

  Then WRITE_REG with writenum=2, vsel=0, write=1; w=1 six edges after s. With the datapath attached, R2 reads 16.
- Load 0xA900 (CMP R1,R0) -> ALU state has loads=1 and loadc=0, then WAIT; write is never asserted.
- Load 0xB880 (MVN R4,R0) -> GET_B (readnum=0), then ALU (ALUop=11), then WRITE_REG (writenum=4). Also drive load=1 with 0xFFFF during execution -> IR unchanged.
- Load 0xE000 (illegal opcode) with s=1 -> DECODE then WAIT with no strobes. Then load=1 and s=1 on the same edge with 0xD102 -> WRITE_IMM writes 0x0002 to R1.
